// File: rtl/range_finder_stats.sv
// Measurement statistics engine: tracks max, min and sample count between go and finish,
// and presents range/max/min/count selected by mode.
module range_finder_stats #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             go,
  input  logic             finish,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             error
);

  if (CNT_W > WIDTH) begin : g_cnt_w_check
    $error("range_finder_stats: CNT_W (%0d) must not exceed WIDTH (%0d)", CNT_W, WIDTH);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] max_r, min_r, max_nxt, min_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             err_r, err_nxt;
  logic             accept;

  // Saturating increment: the counter sticks at all-ones without flagging an error.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] umin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      max_r <= '0;
      min_r <= '1;
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      max_r <= max_nxt;
      min_r <= min_nxt;
      cnt_r <= cnt_nxt;
      err_r <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    max_nxt   = max_r;
    min_nxt   = min_r;
    cnt_nxt   = cnt_r;
    err_nxt   = err_r;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (go && !finish) begin
          state_nxt = RUN;
          err_nxt   = 1'b0;
          max_nxt   = '0;
          min_nxt   = '1;
          cnt_nxt   = '0;
          accept    = valid_in;
        end else if (finish) begin
          err_nxt = 1'b1;
        end
      end
      RUN: begin
        accept = valid_in;
        if (go) begin
          err_nxt = 1'b1;
        end else if (finish) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Sample folds into the (possibly freshly cleared) statistics of this edge.
    if (accept) begin
      max_nxt = umax(max_nxt, data_in);
      min_nxt = umin(min_nxt, data_in);
      cnt_nxt = sat_inc(cnt_nxt);
    end

    if (state == RUN && finish && !go && cnt_nxt == '0) begin
      err_nxt = 1'b1;
    end
  end

  always_comb begin
    result = '0;
    case (mode)
      2'b00:   result = (cnt_r == '0) ? '0 : max_r - min_r;
      2'b01:   result = (cnt_r == '0) ? '0 : max_r;
      2'b10:   result = (cnt_r == '0) ? '0 : min_r;
      default: result = WIDTH'(cnt_r);
    endcase
  end

  assign busy         = (state == RUN);
  assign result_valid = (state == DONE);
  assign count        = cnt_r;
  assign error        = err_r;

endmodule

// File: tb/tb_range_finder_stats.sv
// Directed bench for range_finder_stats (WIDTH=10, CNT_W=4) with hand-computed expectations.
module tb_range_finder_stats;
  localparam int WIDTH = 10;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             go;
  logic             finish;
  logic [1:0]       mode;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             error;

  int total = 0;
  int bad   = 0;

  range_finder_stats #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in),
    .go(go), .finish(finish), .mode(mode), .result(result),
    .result_valid(result_valid), .count(count), .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int exp [4] = '{0, 0, 0, 0};
    for (int m = 0; m < 4; m++) begin
      mode = m[1:0]; #1;
      total++; if (result !== WIDTH'(exp[m])) begin bad++; $display("FAIL reset_result m=%0d got=%0d want=%0d", m, result, exp[m]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b want=0", result_valid); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int exp [4] = '{695, 700, 5, 4};
    go = 1'b1; valid_in = 1'b1; data_in = 10'd100; step();
    total++; if (busy !== 1'b1 || count !== 4'd1) begin bad++; $display("FAIL basic_start busy=%b count=%0d want busy=1 count=1", busy, count); end
    go = 1'b0;
    data_in = 10'd40;  step();
    data_in = 10'd700; step();
    data_in = 10'd5;   step();
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL basic_rv_run got=%b want=0", result_valid); end
    valid_in = 1'b0; finish = 1'b1; step();
    finish = 1'b0;
    total++; if (result_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done rv=%b busy=%b want rv=1 busy=0", result_valid, busy); end
    for (int m = 0; m < 4; m++) begin
      mode = m[1:0]; #1;
      total++; if (result !== WIDTH'(exp[m])) begin bad++; $display("FAIL basic_result m=%0d got=%0d want=%0d", m, result, exp[m]); end
    end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL basic_error got=%b want=0", error); end
    step(); step();
    mode = 2'b00; #1;
    total++; if (result_valid !== 1'b1 || result !== 10'd695) begin bad++; $display("FAIL basic_hold rv=%b result=%0d want rv=1 result=695", result_valid, result); end
  endtask

  task automatic test_protocol();
    finish = 1'b1; step();
    finish = 1'b0;
    total++; if (error !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL proto_finish_idle error=%b busy=%b want error=1 busy=0", error, busy); end
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL proto_finish_keep rv=%b want=1", result_valid); end
    go = 1'b1; step();
    go = 1'b0;
    total++; if (error !== 1'b0 || busy !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL proto_go error=%b busy=%b count=%0d want 0 1 0", error, busy, count); end
    valid_in = 1'b1; data_in = 10'd50; step();
    go = 1'b1; data_in = 10'd60; step();
    go = 1'b0;
    total++; if (error !== 1'b1 || count !== 4'd2 || busy !== 1'b1) begin bad++; $display("FAIL proto_go_run error=%b count=%0d busy=%b want 1 2 1", error, count, busy); end
    data_in = 10'd70; step();
    total++; if (count !== 4'd3 || error !== 1'b1) begin bad++; $display("FAIL proto_keep_count count=%0d error=%b want 3 1", count, error); end
    valid_in = 1'b0; finish = 1'b1; step();
    finish = 1'b0;
    mode = 2'b01; #1;
    total++; if (result !== 10'd70 || error !== 1'b1 || result_valid !== 1'b1) begin bad++; $display("FAIL proto_done max=%0d error=%b rv=%b want 70 1 1", result, error, result_valid); end
    mode = 2'b10; #1;
    total++; if (result !== 10'd50) begin bad++; $display("FAIL proto_min got=%0d want=50", result); end
  endtask

  task automatic test_empty();
    go = 1'b1; step();
    go = 1'b0;
    total++; if (busy !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL empty_start busy=%b error=%b want 1 0", busy, error); end
    finish = 1'b1; step();
    finish = 1'b0;
    total++; if (result_valid !== 1'b1 || error !== 1'b1) begin bad++; $display("FAIL empty_done rv=%b error=%b want 1 1", result_valid, error); end
    for (int m = 0; m < 4; m++) begin
      mode = m[1:0]; #1;
      total++; if (result !== 10'd0) begin bad++; $display("FAIL empty_result m=%0d got=%0d want=0", m, result); end
    end
  endtask

  task automatic test_saturation();
    int exp [4] = '{1013, 1020, 7, 15};
    for (int i = 1; i <= 20; i++) begin
      go = (i == 1); valid_in = 1'b1;
      data_in = (i == 18) ? 10'd1020 : (i == 19) ? 10'd7 : WIDTH'(200 + 10 * i);
      step();
      if (i == 17) begin
        total++; if (count !== 4'd15) begin bad++; $display("FAIL sat_count17 got=%0d want=15", count); end
        mode = 2'b01; #1;
        total++; if (result !== 10'd370) begin bad++; $display("FAIL sat_runmax got=%0d want=370", result); end
        mode = 2'b10; #1;
        total++; if (result !== 10'd210) begin bad++; $display("FAIL sat_runmin got=%0d want=210", result); end
      end
    end
    go = 1'b0; valid_in = 1'b0; finish = 1'b1; step();
    finish = 1'b0;
    total++; if (count !== 4'd15 || error !== 1'b0 || result_valid !== 1'b1) begin bad++; $display("FAIL sat_done count=%0d error=%b rv=%b want 15 0 1", count, error, result_valid); end
    for (int m = 0; m < 4; m++) begin
      mode = m[1:0]; #1;
      total++; if (result !== WIDTH'(exp[m])) begin bad++; $display("FAIL sat_result m=%0d got=%0d want=%0d", m, result, exp[m]); end
    end
  endtask

  task automatic test_simultaneous();
    go = 1'b1; valid_in = 1'b1; data_in = 10'd100; step();
    finish = 1'b1; data_in = 10'd900; step();
    go = 1'b0; finish = 1'b0; valid_in = 1'b0;
    mode = 2'b01; #1;
    total++; if (error !== 1'b1 || busy !== 1'b1 || result_valid !== 1'b0) begin bad++; $display("FAIL simul_run error=%b busy=%b rv=%b want 1 1 0", error, busy, result_valid); end
    total++; if (result !== 10'd900 || count !== 4'd2) begin bad++; $display("FAIL simul_stats max=%0d count=%0d want 900 2", result, count); end
    finish = 1'b1; step();
    finish = 1'b0;
    go = 1'b1; finish = 1'b1; valid_in = 1'b1; data_in = 10'd1000; step();
    go = 1'b0; finish = 1'b0; valid_in = 1'b0;
    #1;
    total++; if (result_valid !== 1'b1 || result !== 10'd900 || count !== 4'd2 || error !== 1'b1) begin bad++; $display("FAIL simul_done rv=%b max=%0d count=%0d error=%b want 1 900 2 1", result_valid, result, count, error); end
  endtask

  task automatic test_async_reset();
    go = 1'b1; valid_in = 1'b1; data_in = 10'd10; step();
    go = 1'b0; data_in = 10'd20; step();
    go = 1'b1; valid_in = 1'b0; step();
    go = 1'b0;
    total++; if (error !== 1'b1 || count !== 4'd2 || busy !== 1'b1) begin bad++; $display("FAIL arst_pre error=%b count=%0d busy=%b want 1 2 1", error, count, busy); end
    #3 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || count !== 4'd0 || error !== 1'b0 || result_valid !== 1'b0) begin bad++; $display("FAIL arst_now busy=%b count=%0d error=%b rv=%b want 0 0 0 0", busy, count, error, result_valid); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    step(); step(); step();
    total++; if (result_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arst_after rv=%b busy=%b want 0 0", result_valid, busy); end
    go = 1'b1; step();
    go = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_go busy=%b want=1", busy); end
  endtask

  initial begin
    reset_n = 1'b1; data_in = '0; valid_in = 1'b0; go = 1'b0; finish = 1'b0; mode = 2'b00;
    #2 reset_n = 1'b0;
    test_reset();
    test_basic();
    test_protocol();
    test_empty();
    test_saturation();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
